// File: rtl/sdram_read_frame.sv
// Avalon-MM burst reader: fetches one frame from DDR and streams it out through a credit-checked FIFO.
// Optional statistics outputs (max_units_in_fifo, count_stall) exist when SDRAM_READ_STAT_EN is defined.
module sdram_read_frame #(
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned FRAME_WORDS = 518400,
    parameter int unsigned BUF_DEPTH   = 128
) (
    input  logic        clk_200,
    input  logic        reset_n,
    input  logic        start_read,
    input  logic [31:0] reg_addr_buf,
    output logic [28:0] avl_address,
    output logic        avl_read,
    output logic [7:0]  avl_burstcount,
    input  logic        avl_waitrequest,
    input  logic [63:0] avl_readdata,
    input  logic        avl_readdatavalid,
    output logic [63:0] data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        busy,
    output logic        end_frame,
    output logic        fifo_err
`ifdef SDRAM_READ_STAT_EN
    ,
    output logic [7:0]  max_units_in_fifo,
    output logic [15:0] count_stall
`endif
);

    localparam int unsigned N_BURSTS = FRAME_WORDS / BURST_LEN;
    localparam int unsigned BL_W     = $clog2(N_BURSTS) + 1;
    localparam int unsigned PTR_W    = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 2;
    localparam int unsigned WO_W     = $clog2(FRAME_WORDS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [28:0]      addr_q, addr_d;
    logic [BL_W-1:0]  bursts_left_q, bursts_left_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [WO_W-1:0]  words_out_q, words_out_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             avl_read_q, avl_read_d;
    logic [28:0]      avl_address_q, avl_address_d;
    logic [7:0]       avl_burstcount_q, avl_burstcount_d;
    logic             valid_out_q, valid_out_d;
    logic [63:0]      data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             end_frame_q, end_frame_d;
    logic             fifo_err_q, fifo_err_d;
    logic [63:0]      mem [BUF_DEPTH];

    logic rdv_live, fifo_full, push, pop, accept, credit_ok, start_acc;
    logic unused_addr_hi;

    assign unused_addr_hi = ^reg_addr_buf[31:29];

    always_comb begin
        rdv_live  = avl_readdatavalid && (state_q != S_IDLE);
        fifo_full = (fifo_cnt_q == CNT_W'(BUF_DEPTH));
        push      = rdv_live && !fifo_full;
        pop       = valid_out_q && ready_in;
        accept    = (state_q == S_REQ) && avl_read_q && !avl_waitrequest;
        credit_ok = (fifo_cnt_q + outstanding_q + CNT_W'(BURST_LEN)) <= CNT_W'(BUF_DEPTH);
        start_acc = (state_q == S_IDLE) && start_read;
    end

    // FIFO bookkeeping and show-ahead head register (next head computed from post-update pointers)
    always_comb begin
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        outstanding_d = outstanding_q + (accept ? CNT_W'(BURST_LEN) : CNT_W'(0))
                        - CNT_W'(avl_readdatavalid && (outstanding_q != '0));
        valid_out_d   = (fifo_cnt_d != '0);
        data_out_d    = data_out_q;
        if (valid_out_d) begin
            data_out_d = (push && (wr_ptr_q == rd_ptr_d)) ? avl_readdata : mem[rd_ptr_d];
        end
        fifo_err_d    = fifo_err_q | (rdv_live && fifo_full);
    end

    // Request/frame control FSM
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        bursts_left_d    = bursts_left_q;
        words_out_d      = words_out_q;
        avl_read_d       = avl_read_q;
        avl_address_d    = avl_address_q;
        avl_burstcount_d = avl_burstcount_q;
        busy_d           = busy_q;
        end_frame_d      = 1'b0;
        if (pop && (state_q != S_IDLE)) begin
            words_out_d = words_out_q + WO_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start_read) begin
                    addr_d        = reg_addr_buf[28:0];
                    bursts_left_d = BL_W'(N_BURSTS);
                    words_out_d   = '0;
                    busy_d        = 1'b1;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bursts_left_q == '0) begin
                    state_d = S_FLUSH;
                end else if (credit_ok) begin
                    avl_read_d       = 1'b1;
                    avl_address_d    = addr_q;
                    avl_burstcount_d = 8'(BURST_LEN);
                    state_d          = S_REQ;
                end
            end
            S_REQ: begin
                if (accept) begin
                    addr_d        = addr_q + 29'(BURST_LEN);
                    bursts_left_d = bursts_left_q - BL_W'(1);
                    avl_read_d    = 1'b0;
                    state_d       = S_CHECK;
                end
            end
            S_FLUSH: begin
                if ((outstanding_q == '0) && (words_out_q == WO_W'(FRAME_WORDS))) begin
                    end_frame_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_200) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            bursts_left_q    <= '0;
            outstanding_q    <= '0;
            fifo_cnt_q       <= '0;
            words_out_q      <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            avl_read_q       <= 1'b0;
            avl_address_q    <= '0;
            avl_burstcount_q <= '0;
            valid_out_q      <= 1'b0;
            data_out_q       <= '0;
            busy_q           <= 1'b0;
            end_frame_q      <= 1'b0;
            fifo_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            bursts_left_q    <= bursts_left_d;
            outstanding_q    <= outstanding_d;
            fifo_cnt_q       <= fifo_cnt_d;
            words_out_q      <= words_out_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            avl_read_q       <= avl_read_d;
            avl_address_q    <= avl_address_d;
            avl_burstcount_q <= avl_burstcount_d;
            valid_out_q      <= valid_out_d;
            data_out_q       <= data_out_d;
            busy_q           <= busy_d;
            end_frame_q      <= end_frame_d;
            fifo_err_q       <= fifo_err_d;
        end
    end

    // Storage array needs no reset; emptiness is tracked by the pointers and count
    always_ff @(posedge clk_200) begin
        if (reset_n && push) begin
            mem[wr_ptr_q] <= avl_readdata;
        end
    end

`ifdef SDRAM_READ_STAT_EN
    logic [7:0]  max_units_q, max_units_d;
    logic [15:0] count_stall_q, count_stall_d;
    logic [7:0]  fifo_cnt_sat;

    always_comb begin
        fifo_cnt_sat  = (32'(fifo_cnt_q) > 32'd255) ? 8'hFF : 8'(fifo_cnt_q);
        max_units_d   = max_units_q;
        count_stall_d = count_stall_q;
        if (start_acc) begin
            max_units_d   = '0;
            count_stall_d = '0;
        end else begin
            if (fifo_cnt_sat > max_units_q) begin
                max_units_d = fifo_cnt_sat;
            end
            if (busy_q && ready_in && !valid_out_q && (count_stall_q != 16'hFFFF)) begin
                count_stall_d = count_stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_200) begin
        if (!reset_n) begin
            max_units_q   <= '0;
            count_stall_q <= '0;
        end else begin
            max_units_q   <= max_units_d;
            count_stall_q <= count_stall_d;
        end
    end

    assign max_units_in_fifo = max_units_q;
    assign count_stall       = count_stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    assign avl_read       = avl_read_q;
    assign avl_address    = avl_address_q;
    assign avl_burstcount = avl_burstcount_q;
    assign valid_out      = valid_out_q;
    assign data_out       = data_out_q;
    assign busy           = busy_q;
    assign end_frame      = end_frame_q;
    assign fifo_err       = fifo_err_q;

endmodule

// File: tb/tb_sdram_read_frame.sv
// Bench for sdram_read_frame: Avalon slave model with a word-addressed memory, stream scoreboard,
// scenario table plus hand sequences for waitrequest, backpressure, restart, reset and statistics.
module tb_sdram_read_frame;

    localparam int unsigned BL    = 32;
    localparam int unsigned FRAME = 256;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned NB    = FRAME / BL;

    logic        clk;
    logic        reset_n;
    logic        start_read;
    logic [31:0] reg_addr_buf;
    logic [28:0] avl_address;
    logic        avl_read;
    logic [7:0]  avl_burstcount;
    logic        avl_waitrequest;
    logic [63:0] avl_readdata;
    logic        avl_readdatavalid;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy;
    logic        end_frame;
    logic        fifo_err;
`ifdef SDRAM_READ_STAT_EN
    logic [7:0]  max_units_in_fifo;
    logic [15:0] count_stall;
`endif

    sdram_read_frame #(.BURST_LEN(BL), .FRAME_WORDS(FRAME), .BUF_DEPTH(DEPTH)) dut (
        .clk_200(clk), .reset_n(reset_n), .start_read(start_read), .reg_addr_buf(reg_addr_buf),
        .avl_address(avl_address), .avl_read(avl_read), .avl_burstcount(avl_burstcount),
        .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in), .busy(busy), .end_frame(end_frame), .fifo_err(fifo_err)
`ifdef SDRAM_READ_STAT_EN
        , .max_units_in_fifo(max_units_in_fifo), .count_stall(count_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DDR content: a fixed function of the word address
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {3'b101, a, 32'(a) * 32'h9E37_79B1};
    endfunction

    // Slave/scoreboard controls (written by the main sequence just after posedge)
    int          wait_pct = 0, ready_pct = 100, gap_pct = 0;
    logic        manual_wait = 1'b0, ready_toggle = 1'b0;
    logic [28:0] exp_base = '0;
    int          acc_cnt = 0, words_seen = 0, end_cnt = 0;
    int          cyc = 0, lvl = 0, peak_model = 0, stall_model = 0;

    typedef struct { int due; logic [63:0] data; } pend_t;
    pend_t pend[$];

    // Avalon slave + stream scoreboard; inputs change on negedge, DUT samples them on posedge
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            pend.delete();
            avl_readdatavalid = 1'b0;
            avl_waitrequest   = 1'b0;
            lvl               = 0;
        end else begin
            check("valid_vs_model", valid_out, 64'(lvl != 0));
            if (ready_toggle) ready_in = ~ready_in;
            else              ready_in = (int'($urandom_range(99)) < ready_pct);
            if (valid_out && ready_in) begin
                check("stream_word", data_out, mem_word(29'(exp_base + 29'(words_seen))));
                words_seen++;
            end
            if (end_frame) begin
                end_cnt++;
                check("end_after_last_word", 64'(words_seen), 64'(FRAME));
            end
            avl_waitrequest = manual_wait || (int'($urandom_range(99)) < wait_pct);
            if (avl_read && !avl_waitrequest) begin
                check("burst_addr", 64'(avl_address), 64'(29'(exp_base + 29'(acc_cnt * BL))));
                check("burstcount", 64'(avl_burstcount), 64'(BL));
                for (int i = 0; i < int'(BL); i++)
                    pend.push_back('{cyc + 4, mem_word(29'(avl_address + 29'(i)))});
                acc_cnt++;
            end
            if (pend.size() != 0 && pend[0].due <= cyc && int'($urandom_range(99)) >= gap_pct) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = pend[0].data;
                void'(pend.pop_front());
            end else begin
                avl_readdatavalid = 1'b0;
                avl_readdata      = {$urandom(), $urandom()};
            end
            if (start_read && !busy) begin
                stall_model = 0;
                peak_model  = 0;
            end else if (busy && ready_in && !valid_out) begin
                stall_model++;
            end
            if (avl_readdatavalid && busy && lvl < int'(DEPTH)) lvl++;
            if (valid_out && ready_in) lvl--;
            if (lvl > peak_model) peak_model = lvl;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] base);
        exp_base     = base[28:0];
        acc_cnt      = 0;
        words_seen   = 0;
        end_cnt      = 0;
        reg_addr_buf = base;
        start_read   = 1'b1;
        tick();
        start_read   = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_end(input int exp_bursts, input int exp_words);
        int n = 0;
        while (end_cnt == 0 && n < 20000) begin
            tick();
            n++;
        end
        check("end_within_budget", 64'(n < 20000), 1);
        repeat (4) tick();
        check("end_frame_once", 64'(end_cnt), 1);
        check("bursts_total", 64'(acc_cnt), 64'(exp_bursts));
        check("words_total", 64'(words_seen), 64'(exp_words));
        check("busy_after_end", busy, 0);
        check("fifo_err_clear", fifo_err, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_avl_read", avl_read, 0);
        check("rst_avl_address", 64'(avl_address), 0);
        check("rst_avl_burstcount", 64'(avl_burstcount), 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_end_frame", end_frame, 0);
        check("rst_fifo_err", fifo_err, 0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          wait_p;
        int          ready_p;
        int          gap_p;
        int          exp_bursts;
        int          exp_words;
    } vec_t;

    vec_t vec[5];

    initial begin
        int n;
        logic [28:0] snap_addr;
        logic [7:0]  snap_bc;

        vec[0] = '{32'h0000_1000, 0, 100, 0, NB, FRAME};
        vec[1] = '{32'hE000_1000, 30, 70, 20, NB, FRAME};
        vec[2] = '{32'h1FFF_FFC0, 20, 50, 30, NB, FRAME};
        vec[3] = '{$urandom(), 50, 30, 50, NB, FRAME};
        vec[4] = '{$urandom(), 10, 90, 10, NB, FRAME};

        reset_n = 1'b0; start_read = 1'b0; reg_addr_buf = '0; ready_in = 1'b0;
        avl_waitrequest = 1'b0; avl_readdata = '0; avl_readdatavalid = 1'b0;
        tick(); tick();
        check_reset_outputs();
        reset_n = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) begin
            wait_pct = vec[t].wait_p; ready_pct = vec[t].ready_p; gap_pct = vec[t].gap_p;
            start_frame(vec[t].base);
            wait_end(vec[t].exp_bursts, vec[t].exp_words);
        end
        wait_pct = 0; ready_pct = 100; gap_pct = 0;

        // Waitrequest held on the first request: command must stay stable
        manual_wait = 1'b1;
        start_frame(32'h0000_4000);
        n = 0;
        while (!avl_read && n < 50) begin tick(); n++; end
        check("req_seen", avl_read, 1);
        snap_addr = avl_address;
        snap_bc   = avl_burstcount;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_read_held", avl_read, 1);
            check("wait_addr_held", 64'(avl_address), 64'(snap_addr));
            check("wait_bc_held", 64'(avl_burstcount), 64'(snap_bc));
        end
        check("no_accept_in_wait", 64'(acc_cnt), 0);
        manual_wait = 1'b0;
        wait_end(NB, FRAME);

        // Downstream stalled: credit limits to DEPTH/BL bursts
        ready_pct = 0;
        start_frame(32'h0001_0000);
        repeat (400) tick();
        check("bp_bursts", 64'(acc_cnt), 64'(DEPTH / BL));
        check("bp_read_idle", avl_read, 0);
        check("bp_valid", valid_out, 1);
        check("bp_fifo_err", fifo_err, 0);
        check("bp_words", 64'(words_seen), 0);
        ready_pct = 100;
        wait_end(NB, FRAME);

        // start_read mid-frame is ignored
        ready_pct = 60;
        start_frame(32'h0002_0000);
        n = 0;
        while (acc_cnt < 3 && n < 2000) begin tick(); n++; end
        reg_addr_buf = 32'h0555_0000;
        start_read   = 1'b1;
        tick();
        start_read   = 1'b0;
        check("busy_after_restart", busy, 1);
        wait_end(NB, FRAME);
        ready_pct = 100;

        // Reset mid-burst aborts, then a fresh frame reads correctly
        start_frame(32'h0003_0000);
        n = 0;
        while (acc_cnt < 2 && n < 2000) begin tick(); n++; end
        reset_n = 1'b0;
        tick();
        check_reset_outputs();
        reset_n = 1'b1;
        tick();
        check("no_end_after_reset", 64'(end_cnt), 0);
        start_frame(32'h0000_2000);
        wait_end(NB, FRAME);

        // ready_in toggling every cycle
        ready_toggle = 1'b1;
        start_frame(32'h0004_0000);
        wait_end(NB, FRAME);
`ifdef SDRAM_READ_STAT_EN
        check("stat_peak", 64'(max_units_in_fifo), 64'(peak_model));
        check("stat_peak_bound", 64'(max_units_in_fifo <= 8'(DEPTH)), 1);
        check("stat_stall", 64'(count_stall), 64'(stall_model));
`endif
        ready_toggle = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_read_frame.md
Name: sdram_read_frame

Overview:
Avalon-MM burst read master that fetches one video frame from a DDR frame buffer and presents it as a 64-bit valid/ready stream to the downstream HDR processing pipeline. It is the consumer-side counterpart of the frame writer: same buffer base-address register, same 32-word burst, same word addressing. A credit-checked internal FIFO absorbs read latency and downstream backpressure, so the FIFO can never overflow.

Parameters:
BURST_LEN, 32, words per Avalon burst (1..128).
FRAME_WORDS, 518400, 64-bit words per frame; must be a multiple of BURST_LEN.
BUF_DEPTH, 128, internal FIFO depth in words; power of 2, >= 2*BURST_LEN.

Ports:
clk_200  in  1  single clock for the whole block.
reset_n  in  1  synchronous, active-low reset.
start_read  in  1  one-cycle pulse that starts a frame read.
reg_addr_buf  in  32  frame buffer base word address; bits [28:0] are used.
avl_address  out  29  Avalon word address.
avl_read  out  1  Avalon read request.
avl_burstcount  out  8  burst length.
avl_waitrequest  in  1  Avalon stall.
avl_readdata  in  64  read data.
avl_readdatavalid  in  1  read data valid.
data_out  out  64  stream data.
valid_out  out  1  stream valid.
ready_in  in  1  downstream ready.
busy  out  1  high from the accepted start until end_frame.
end_frame  out  1  one-cycle pulse when the last word of the frame is consumed.
fifo_err  out  1  sticky: readdatavalid arrived while the FIFO was full.

Behaviour:
- Reset (synchronous, next edge with reset_n low) clears all of the following: state=IDLE; avl_read=0; avl_address=0; avl_burstcount=0; valid_out=0; data_out=0; busy=0; end_frame=0; fifo_err=0; FIFO emptied; all counters zeroed.
- A reset mid-frame aborts the frame immediately, with no end_frame. The DDR controller shares this reset, so no stale read data is expected.
- Counters:
  - bursts_left: width clog2(FRAME_WORDS/BURST_LEN)+1.
  - outstanding: words requested but not yet returned.
  - fifo_cnt.
  - words_out: words consumed this frame.
- Credit: space = BUF_DEPTH - fifo_cnt - outstanding. A burst is issued only when space >= BURST_LEN.
- State IDLE:
  - start_read=1 latches base=reg_addr_buf[28:0], sets bursts_left=FRAME_WORDS/BURST_LEN, asserts busy, and goes to CHECK.
  - start_read while busy is ignored.
- State CHECK:
  - bursts_left==0 goes to FLUSH.
  - Otherwise, if the credit condition holds, next cycle drives avl_read=1, avl_address=addr, avl_burstcount=BURST_LEN, and goes to REQ.
  - Otherwise stays in CHECK.
- State REQ:
  - avl_read, avl_address and avl_burstcount are held stable while avl_waitrequest=1.
  - On the cycle avl_read=1 and avl_waitrequest=0 (accept): outstanding += BURST_LEN; addr += BURST_LEN; bursts_left -= 1; avl_read=0 next cycle; go to CHECK.
- Simultaneous accept and readdatavalid in one cycle: outstanding += BURST_LEN-1.
- Address arithmetic is 29-bit and wraps modulo 2^29 with no flag.
- State FLUSH: when outstanding==0 and words_out==FRAME_WORDS, pulse end_frame for one cycle, clear busy, go to IDLE.
- readdatavalid writes avl_readdata into the FIFO; outstanding -= 1.
  - readdatavalid is accepted in any state.
  - In IDLE the data is dropped.
  - If the FIFO is full, the word is dropped and fifo_err is set (unreachable when the credit rule holds).
- Output is show-ahead: valid_out = FIFO not empty, and data_out = head word.
  - A transfer occurs when valid_out & ready_in; it pops the FIFO and increments words_out.
  - Latency from readdatavalid to valid_out with the FIFO empty: 1 cycle.
  - Simultaneous push and pop leave fifo_cnt unchanged.
- valid_out must not depend combinationally on ready_in.

Optional Feature:
Macro SDRAM_READ_STAT_EN.
- Defined: adds two outputs.
  - max_units_in_fifo [7:0]: peak fifo_cnt since start_read, saturating at 255.
  - count_stall [15:0]: cycles with busy=1, ready_in=1 and valid_out=0; saturates at 0xFFFF.
  - Both are cleared on reset and on an accepted start_read.
- Not defined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- FRAME_WORDS=64, BURST_LEN=32, base 0x1000, waitrequest=0, readdatavalid 4 cycles after accept, ready_in=1 -> two bursts at addresses 0x1000 and 0x1020 with burstcount=32; 64 words out in order; one end_frame pulse; busy low afterwards.
- waitrequest held high 5 cycles on the first request -> avl_read, avl_address and avl_burstcount stable all 5 cycles; exactly 2 accepts total.
- ready_in=0 throughout, BUF_DEPTH=128 -> exactly 4 bursts issued, then avl_read stays 0; fifo_cnt=128; fifo_err=0; releasing ready_in resumes issuing.
- start_read pulsed again mid-frame -> ignored; base and counters unchanged.
- reset_n low for 1 cycle mid-burst -> next cycle all outputs at reset values; a following start_read reads the full frame correctly.
- With SDRAM_READ_STAT_EN defined and ready_in toggling 1-of-2 cycles -> max_units_in_fifo <= 128; count_stall matches the bench's own count.
